ahb_dma_master: RTL and testbench

- AHB-Lite bus master that copies a block of 32-bit words from a source address range to a destination address range.
- Sits beside the Cortex-M0 as the other end of the AHB-Lite bus: it drives the address and control phase, and the slaves respond.
- Commands come from a simple valid/ready port.
- Source and destination can each be held at a fixed address, so a peripheral data register (e.g. UART or SPI) can be streamed to or from block RAM.

---
 rtl/ahb_pkg.sv | 33 +++
 rtl/ahb_dma_master.sv | 206 ++++++++++++++++++++
 tb/tb_ahb_dma_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, DMA state type and address helpers.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_ADDR = 3'd3,
      WR_DATA = 3'd4,
      ERR     = 3'd5,
      FINISH  = 3'd6
   } dma_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   // Fixed addresses model a peripheral data register; otherwise step one word.
   function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic fix);
      logic [31:0] nxt;
      if (fix) begin
         nxt = addr;
      end else begin
         nxt = addr + 32'd4;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/ahb_dma_master.sv
// AHB-Lite DMA master: copies cmd_count words from src to dst, one read then
// one write per word, with all bus-facing outputs driven from flops.
module ahb_dma_master
   import ahb_pkg::*;
#(
   parameter int         COUNT_W   = 12,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic               HCLK,
   input  logic               resetHW,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [31:0]        cmd_src,
   input  logic [31:0]        cmd_dst,
   input  logic [COUNT_W-1:0] cmd_count,
   input  logic               cmd_src_fix,
   input  logic               cmd_dst_fix,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [COUNT_W-1:0] words_done,
   output logic [31:0]        HADDR,
   output logic [1:0]         HTRANS,
   output logic               HWRITE,
   output logic [2:0]         HSIZE,
   output logic [3:0]         HPROT,
   output logic [31:0]        HWDATA,
   input  logic [31:0]        HRDATA,
   input  logic               HREADY,
   input  logic               HRESP
);

   dma_state_t         state_q, state_d;
   logic [31:0]        src_q, src_d, dst_q, dst_d;
   logic [31:0]        data_q, data_d;
   logic [31:0]        haddr_q, haddr_d;
   logic [COUNT_W-1:0] remaining_q, remaining_d;
   logic [COUNT_W-1:0] words_done_q, words_done_d;
   logic [1:0]         htrans_q, htrans_d;
   logic               src_fix_q, src_fix_d, dst_fix_q, dst_fix_d;
   logic               hwrite_q, hwrite_d;
   logic               error_q, error_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               cmd_ready_q, cmd_ready_d;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      data_d       = data_q;
      remaining_d  = remaining_q;
      words_done_d = words_done_q;
      src_fix_d    = src_fix_q;
      dst_fix_d    = dst_fix_q;
      error_d      = error_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               src_d        = word_align(cmd_src);
               dst_d        = word_align(cmd_dst);
               remaining_d  = cmd_count;
               src_fix_d    = cmd_src_fix;
               dst_fix_d    = cmd_dst_fix;
               error_d      = 1'b0;
               words_done_d = {COUNT_W{1'b0}};
               if (cmd_count == {COUNT_W{1'b0}}) begin
                  state_d = FINISH;
               end else begin
                  state_d = RD_ADDR;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_ADDR: begin
            if (HREADY) begin
               state_d = RD_DATA;
            end else begin
               state_d = RD_ADDR;
            end
         end
         RD_DATA: begin
            if (HRESP) begin
               error_d = 1'b1;
               state_d = ERR;
            end else if (HREADY) begin
               data_d  = HRDATA;
               state_d = WR_ADDR;
            end else begin
               state_d = RD_DATA;
            end
         end
         WR_ADDR: begin
            if (HREADY) begin
               state_d = WR_DATA;
            end else begin
               state_d = WR_ADDR;
            end
         end
         WR_DATA: begin
            if (HRESP) begin
               error_d = 1'b1;
               state_d = ERR;
            end else if (HREADY) begin
               words_done_d = words_done_q + COUNT_W'(1);
               src_d        = step_addr(src_q, src_fix_q);
               dst_d        = step_addr(dst_q, dst_fix_q);
               remaining_d  = remaining_q - COUNT_W'(1);
               if (remaining_q == COUNT_W'(1)) begin
                  state_d = FINISH;
               end else begin
                  state_d = RD_ADDR;
               end
            end else begin
               state_d = WR_DATA;
            end
         end
         ERR: begin
            error_d = 1'b1;
            state_d = FINISH;
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Bus outputs are derived from the state being entered so they are flop outputs.
      case (state_d)
         RD_ADDR: begin
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b0;
            haddr_d  = src_d;
         end
         WR_ADDR: begin
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b1;
            haddr_d  = dst_d;
         end
         default: begin
            htrans_d = HTRANS_IDLE;
            hwrite_d = hwrite_q;
            haddr_d  = haddr_q;
         end
      endcase

      done_d      = (state_d == FINISH);
      busy_d      = (state_d != IDLE);
      cmd_ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge HCLK) begin
      if (resetHW) begin
         state_q      <= IDLE;
         src_q        <= 32'h0000_0000;
         dst_q        <= 32'h0000_0000;
         data_q       <= 32'h0000_0000;
         haddr_q      <= 32'h0000_0000;
         remaining_q  <= {COUNT_W{1'b0}};
         words_done_q <= {COUNT_W{1'b0}};
         htrans_q     <= HTRANS_IDLE;
         src_fix_q    <= 1'b0;
         dst_fix_q    <= 1'b0;
         hwrite_q     <= 1'b0;
         error_q      <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         cmd_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         data_q       <= data_d;
         haddr_q      <= haddr_d;
         remaining_q  <= remaining_d;
         words_done_q <= words_done_d;
         htrans_q     <= htrans_d;
         src_fix_q    <= src_fix_d;
         dst_fix_q    <= dst_fix_d;
         hwrite_q     <= hwrite_d;
         error_q      <= error_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         cmd_ready_q  <= cmd_ready_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign words_done = words_done_q;
   assign HADDR      = haddr_q;
   assign HTRANS     = htrans_q;
   assign HWRITE     = hwrite_q;
   assign HSIZE      = HSIZE_WORD;
   assign HPROT      = HPROT_VAL;
   assign HWDATA     = data_q;

endmodule

// File: tb/tb_ahb_dma_master.sv
// Self-checking bench: AHB-Lite slave/memory model plus a word-copy reference model.
module tb_ahb_dma_master;

   localparam logic [31:0] FIFO_ADDR = 32'h5100_0000;

   logic        HCLK;
   logic        resetHW;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_src;
   logic [31:0] cmd_dst;
   logic [11:0] cmd_count;
   logic        cmd_src_fix;
   logic        cmd_dst_fix;
   logic        busy;
   logic        done;
   logic        error;
   logic [11:0] words_done;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA = 32'h0000_0000;
   logic        HREADY = 1'b1;
   logic        HRESP  = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   ahb_dma_master #(.COUNT_W(12), .HPROT_VAL(4'b0011)) dut (
      .HCLK(HCLK), .resetHW(resetHW),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_count(cmd_count),
      .cmd_src_fix(cmd_src_fix), .cmd_dst_fix(cmd_dst_fix),
      .busy(busy), .done(done), .error(error), .words_done(words_done),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Slave memory and reference memory (unwritten words return an address-derived pattern)
   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'hC3C3_0000;
   endfunction
   function logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return dflt(a);
   endfunction
   function logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return dflt(a);
   endfunction

   // Slave state
   bit          dp_act = 1'b0;
   bit          dp_wr;
   bit          dp_err;
   logic [31:0] dp_addr;
   logic [31:0] hw_hold;
   bit          hw_valid;
   int          wait_left;
   int          err_stage;
   int          waits_cfg   = 0;
   int          err_rd_idx  = -1;
   int          rd_seen     = 0;
   int          fifo_idx    = 0;
   int          ref_fifo    = 0;
   int          n_accept    = 0;
   logic [32:0] addr_log[$];

   // Slave response drive, away from the active edge
   always @(negedge HCLK) begin
      if (!dp_act) begin
         HREADY = 1'b1; HRESP = 1'b0;
      end else if (dp_err) begin
         HREADY = (err_stage == 1); HRESP = 1'b1;
      end else if (wait_left > 0) begin
         HREADY = 1'b0; HRESP = 1'b0;
      end else begin
         HREADY = 1'b1; HRESP = 1'b0;
         if (!dp_wr) HRDATA = (dp_addr == FIFO_ADDR) ? (32'hA0 + fifo_idx) : mem_rd(dp_addr);
      end
   end

   // Slave phase tracking on the active edge (sees pre-edge DUT outputs)
   always @(posedge HCLK) begin
      bit hr;
      hr = HREADY;
      if (resetHW) begin
         dp_act = 1'b0;
      end else begin
         if (dp_act) begin
            check("dphase_htrans", HTRANS, 2'b00);
            check("dphase_haddr", HADDR, dp_addr);
            if (dp_wr) begin
               if (!hw_valid) begin hw_hold = HWDATA; hw_valid = 1'b1; end
               else check("hwdata_stable", HWDATA, hw_hold);
            end
            if (dp_err) begin
               if (err_stage == 0) err_stage = 1; else dp_act = 1'b0;
            end else if (wait_left > 0) begin
               wait_left--;
            end else begin
               if (dp_wr) mem[dp_addr] = HWDATA;
               else if (dp_addr == FIFO_ADDR) fifo_idx++;
               dp_act = 1'b0;
            end
         end
         if (hr && HTRANS == 2'b10) begin
            check("hsize", HSIZE, 3'b010);
            check("hprot", HPROT, 4'b0011);
            addr_log.push_back({HWRITE, HADDR});
            dp_act    = 1'b1;
            dp_wr     = HWRITE;
            dp_addr   = HADDR;
            wait_left = waits_cfg;
            hw_valid  = 1'b0;
            err_stage = 0;
            dp_err    = !HWRITE && (rd_seen == err_rd_idx);
            if (!HWRITE) rd_seen++;
         end
      end
      if (!resetHW && cmd_valid && cmd_ready) n_accept++;
   end

   // Issue one command, predict it from the copy rules, and check everything afterwards
   task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst, input int n,
                          input bit sf, input bit df, input int w, input int err_idx,
                          input bit hold, input string tag);
      logic [31:0] s, d, v;
      logic [32:0] exp_log[$];
      logic [31:0] wr_addrs[$];
      int wd, exp_lat, lat;
      bit got, err_hit;
      waits_cfg = w; err_rd_idx = err_idx; rd_seen = 0; addr_log.delete(); n_accept = 0;
      s = src & 32'hFFFF_FFFC; d = dst & 32'hFFFF_FFFC; wd = 0; err_hit = 1'b0;
      for (int i = 0; i < n; i++) begin
         exp_log.push_back({1'b0, s});
         if (i == err_idx) begin err_hit = 1'b1; break; end
         if (s == FIFO_ADDR) begin v = 32'hA0 + ref_fifo; ref_fifo++; end
         else v = ref_rd(s);
         exp_log.push_back({1'b1, d});
         ref_mem[d] = v; wr_addrs.push_back(d); wd++;
         if (!sf) s = s + 32'd4;
         if (!df) d = d + 32'd4;
      end
      exp_lat = (n == 0) ? 1 : (err_hit ? err_idx * (4 + 2 * w) + 4 : n * (4 + 2 * w) + 1);

      @(negedge HCLK);
      check({tag, "/ready_before"}, cmd_ready, 1'b1);
      cmd_src = src; cmd_dst = dst; cmd_count = 12'(n);
      cmd_src_fix = sf; cmd_dst_fix = df; cmd_valid = 1'b1;
      @(posedge HCLK); #1;
      if (!hold) cmd_valid = 1'b0;
      check({tag, "/busy_accept"}, busy, 1'b1);
      check({tag, "/ready_accept"}, cmd_ready, 1'b0);
      check({tag, "/error_cleared"}, error, 1'b0);
      check({tag, "/wd_cleared"}, words_done, 12'd0);
      got = 1'b0; lat = 0;
      while (lat < 3000 && !got) begin
         @(negedge HCLK); lat++;
         if (done === 1'b1) got = 1'b1;
      end
      cmd_valid = 1'b0;
      check({tag, "/done_seen"}, got, 1'b1);
      check({tag, "/done_latency"}, lat, exp_lat);
      check({tag, "/words_done"}, words_done, 12'(wd));
      check({tag, "/error"}, error, err_hit);
      @(posedge HCLK); #1;
      check({tag, "/done_pulse"}, done, 1'b0);
      check({tag, "/busy_after"}, busy, 1'b0);
      check({tag, "/ready_after"}, cmd_ready, 1'b1);
      check({tag, "/error_sticky"}, error, err_hit);
      check({tag, "/accepts"}, n_accept, 1);
      check({tag, "/n_xfers"}, addr_log.size(), exp_log.size());
      for (int i = 0; i < exp_log.size() && i < addr_log.size(); i++)
         check({tag, "/xfer"}, addr_log[i], exp_log[i]);
      foreach (wr_addrs[i]) check({tag, "/mem"}, mem_rd(wr_addrs[i]), ref_rd(wr_addrs[i]));
   endtask

   logic [31:0] rs, rdst, tmp;
   int          n_done_seen;
   bit          seen;

   initial begin
      resetHW = 1'b1; cmd_valid = 1'b0; cmd_src = 32'h0; cmd_dst = 32'h0;
      cmd_count = 12'd0; cmd_src_fix = 1'b0; cmd_dst_fix = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tmp = 32'h1111_1111 * (i + 1);
         mem[32'h2000_0000 + 4 * i] = tmp; ref_mem[32'h2000_0000 + 4 * i] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
         tmp = $urandom;
         mem[32'h2000_0400 + 4 * i] = tmp; ref_mem[32'h2000_0400 + 4 * i] = tmp;
      end

      repeat (3) @(posedge HCLK);
      #1;
      check("rst_htrans", HTRANS, 2'b00);
      check("rst_haddr", HADDR, 32'h0);
      check("rst_hwrite", HWRITE, 1'b0);
      check("rst_hwdata", HWDATA, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_wd", words_done, 12'd0);
      check("rst_ready", cmd_ready, 1'b1);
      @(negedge HCLK); resetHW = 1'b0;

      run_cmd(32'h2000_0000, 32'h2000_0100, 4, 1'b0, 1'b0, 0, -1, 1'b0, "copy4");
      check("copy4/word3", mem_rd(32'h2000_010C), 32'h4444_4444);
      run_cmd(32'h2000_0000, 32'h2000_0200, 4, 1'b0, 1'b0, 2, -1, 1'b0, "copy4_wait");
      run_cmd(32'h2000_0000, 32'h2000_0300, 0, 1'b0, 1'b0, 0, -1, 1'b0, "zero");
      run_cmd(FIFO_ADDR, 32'h2000_0000, 3, 1'b1, 1'b0, 0, -1, 1'b0, "fifo");
      check("fifo/word2", mem_rd(32'h2000_0008), 32'h0000_00A2);
      run_cmd(32'h2000_0400, 32'h2000_0300, 4, 1'b0, 1'b0, 0, 1, 1'b0, "rd_err");
      run_cmd(32'h2000_0410, 32'h2000_0320, 2, 1'b0, 1'b0, 1, -1, 1'b0, "after_err");
      run_cmd(32'hFFFF_FFFA, 32'h2000_0600, 3, 1'b0, 1'b0, 0, -1, 1'b0, "wrap");
      run_cmd(32'h2000_0420, 32'h2000_0340, 3, 1'b0, 1'b0, 0, -1, 1'b1, "hold");

      // Reset pulse while a write data phase is in flight
      @(negedge HCLK);
      cmd_src = 32'h2000_0440; cmd_dst = 32'h2000_0360; cmd_count = 12'd4;
      cmd_src_fix = 1'b0; cmd_dst_fix = 1'b0; cmd_valid = 1'b1;
      waits_cfg = 0; err_rd_idx = -1; rd_seen = 0;
      @(posedge HCLK); #1; cmd_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge HCLK);
         if (HTRANS === 2'b10 && HWRITE === 1'b1) seen = 1'b1;
      end
      check("midrst/wr_addr_seen", seen, 1'b1);
      @(negedge HCLK); resetHW = 1'b1;
      @(posedge HCLK); #1;
      check("midrst/htrans", HTRANS, 2'b00);
      check("midrst/busy", busy, 1'b0);
      check("midrst/ready", cmd_ready, 1'b1);
      check("midrst/done", done, 1'b0);
      check("midrst/haddr", HADDR, 32'h0);
      @(negedge HCLK); resetHW = 1'b0;
      n_done_seen = 0;
      repeat (8) begin
         @(negedge HCLK);
         if (done === 1'b1) n_done_seen++;
      end
      check("midrst/no_done", n_done_seen, 0);
      check("midrst/partial_not_written", mem_rd(32'h2000_0360), ref_rd(32'h2000_0360));

      for (int r = 0; r < 6; r++) begin
         rs   = 32'h2000_0400 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
         rdst = (($urandom_range(0, 1) == 1) ? 32'h2000_0400 : 32'h2000_0800)
                + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
         run_cmd(rs, rdst, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                 $urandom_range(0, 9), 1'b0, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
